// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: register/word types, opcode/funct encodings, NOP and IF/ID payload.
package mips_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FIELD_W = 6;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [FIELD_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [FIELD_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [FIELD_W-1:0] OP_LW    = 6'h23;
  localparam logic [FIELD_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FIELD_W-1:0] FN_ADD = 6'h20;
  localparam logic [FIELD_W-1:0] FN_SUB = 6'h22;
  localparam logic [FIELD_W-1:0] FN_AND = 6'h24;
  localparam logic [FIELD_W-1:0] FN_OR  = 6'h25;
  localparam logic [FIELD_W-1:0] FN_SLT = 6'h2A;

  localparam word_t NOP_INSTR = 32'h0000_0000;

  // Instruction half of the IF/ID pipeline register
  typedef struct packed {
    word_t instr;
    logic  valid;
  } if_id_t;

endpackage

// File: rtl/regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 hard-wired to zero.
// Same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  reg_addr_t         ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  reg_addr_t         rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  reg_addr_t         waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int unsigned IDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;

  logic [DATA_W-1:0] mem [REG_N];

  function automatic logic in_range(input reg_addr_t a);
    return 32'(a) < REG_N;
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input reg_addr_t a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a != '0 && in_range(a)) v = mem[IDX_W'(a)];
`ifdef RF_BYPASS_EN
    if (we && waddr != '0 && waddr == a && in_range(a)) v = wdata;
`endif
    return v;
  endfunction

  // Write port; reset clears every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_N; i++) mem[IDX_W'(i)] <= '0;
    end else if (we && waddr != '0 && in_range(waddr)) begin
      mem[IDX_W'(waddr)] <= wdata;
    end
  end

  always_comb ra_data = read_port(ra_addr);
  always_comb rb_data = read_port(rb_addr);

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, field decode, load-use stall, branch target.
// Optional same-cycle register-file bypass: define RF_BYPASS_EN.
module id_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  word_t              if_instr,
  input  logic [DATA_W-1:0]  if_pc4,
  input  logic               if_valid,
  input  logic               flush,
  input  logic               ex_memread,
  input  reg_addr_t          ex_rt,
  input  logic               wb_we,
  input  reg_addr_t          wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               stall_out,
  output logic               id_valid,
  output logic [5:0]         id_opcode,
  output logic [5:0]         id_funct,
  output reg_addr_t          id_rs,
  output reg_addr_t          id_rt,
  output reg_addr_t          id_rd,
  output logic [DATA_W-1:0]  id_rs_data,
  output logic [DATA_W-1:0]  id_rt_data,
  output logic [DATA_W-1:0]  id_imm,
  output logic [DATA_W-1:0]  id_pc4,
  output logic [DATA_W-1:0]  id_br_target
);

  if_id_t            ifid_q, ifid_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;

  assign id_opcode = ifid_q.instr[31:26];
  assign id_rs     = ifid_q.instr[25:21];
  assign id_rt     = ifid_q.instr[20:16];
  assign id_rd     = ifid_q.instr[15:11];
  assign id_funct  = ifid_q.instr[5:0];
  assign id_imm    = {{(DATA_W-16){ifid_q.instr[15]}}, ifid_q.instr[15:0]};
  assign id_pc4    = pc4_q;
  assign id_br_target = pc4_q + (id_imm << 2);

  // Load-use hazard; a flush kills the dependent instruction so no stall is needed
  assign stall_out = ifid_q.valid && ex_memread && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt)) && !flush;
  assign id_valid  = ifid_q.valid && !stall_out;

  // IF/ID next state: flush beats stall beats load
  always_comb begin
    ifid_d = ifid_q;
    pc4_d  = pc4_q;
    if (flush) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
      pc4_d        = '0;
    end else if (!stall_out) begin
      ifid_d.instr = if_instr;
      ifid_d.valid = if_valid;
      pc4_d        = if_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.valid <= 1'b0;
      pc4_q        <= '0;
    end else begin
      ifid_q <= ifid_d;
      pc4_q  <= pc4_d;
    end
  end

  regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (id_rs),
    .ra_data (id_rs_data),
    .rb_addr (id_rt),
    .rb_data (id_rt_data),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

endmodule
